// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: instruction-memory request/response, redirect input and
// the instruction handshake toward the pipeline. The master side is the fetch queue.
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_data, inst_pc, inst_pc_plus4,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_data, inst_pc, inst_pc_plus4,
    output inst_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the PC, issues sequential fetches to an in-order
// variable-latency memory, buffers responses with their PC and supports redirect/flush.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst_n,
  fetch_queue_if.master fq
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     data_mem [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [DEPTH-1:0] filled_nxt;
  ptr_t head;
  ptr_t fill;
  ptr_t tail;
  // alloc: entries owned by the queue; pend: requested but unanswered; drop: stale responses still due
  cnt_t alloc;
  cnt_t pend;
  cnt_t drop;

  logic        req_valid;
  logic        req_fire;
  logic        rsp_drop;
  logic        rsp_keep;
  logic        deq;
  logic        inst_valid;
  logic [CW:0] used;

  always_comb begin
    used       = {1'b0, alloc} + {1'b0, drop};
    req_valid  = (used < DEPTH_C) && !fq.redirect_valid;
    req_fire   = req_valid && fq.imem_req_ready;
    rsp_drop   = fq.imem_rsp_valid && (drop != '0);
    // A response with nothing outstanding is a protocol violation and is ignored
    rsp_keep   = fq.imem_rsp_valid && (drop == '0) && (pend != '0);
    inst_valid = filled[head];
    deq        = inst_valid && fq.inst_ready;
  end

  always_comb begin
    filled_nxt = filled;
    if (rsp_keep) filled_nxt[fill] = 1'b1;
    if (deq)      filled_nxt[head] = 1'b0;
  end

  assign fq.imem_req_valid = req_valid;
  assign fq.imem_req_addr  = fetch_pc;
  assign fq.inst_valid     = inst_valid;
  assign fq.inst_data      = data_mem[head];
  assign fq.inst_pc        = pc_mem[head];
  assign fq.inst_pc_plus4  = pc_mem[head] + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      fill     <= '0;
      tail     <= '0;
      alloc    <= '0;
      pend     <= '0;
      drop     <= '0;
      filled   <= '0;
    end else if (fq.redirect_valid) begin
      fetch_pc <= {fq.redirect_pc[XLEN-1:2], 2'b00};
      head     <= '0;
      fill     <= '0;
      tail     <= '0;
      alloc    <= '0;
      pend     <= '0;
      filled   <= '0;
      // Everything still owed by memory becomes a stale response, less whatever lands this cycle
      drop     <= pend + drop - cnt_t'(rsp_keep) - cnt_t'(rsp_drop);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        tail     <= tail + ptr_t'(1);
      end
      if (rsp_keep) fill <= fill + ptr_t'(1);
      if (deq)      head <= head + ptr_t'(1);
      alloc  <= alloc + cnt_t'(req_fire) - cnt_t'(deq);
      pend   <= pend + cnt_t'(req_fire) - cnt_t'(rsp_keep);
      drop   <= drop - cnt_t'(rsp_drop);
      filled <= filled_nxt;
    end
  end

  // Payload storage carries no reset; the filled bits qualify it
  always_ff @(posedge clk) begin
    if (req_fire) pc_mem[tail]   <= fetch_pc;
    if (rsp_keep) data_mem[fill] <= fq.imem_rsp_data;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order variable-latency memory, transaction-level reference
// model (request/instruction queues tagged with a redirect epoch), table and directed cases.
module tb_fetch_queue;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(XLEN)) f ();

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .fq   (f)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          epoch;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } inst_t;

  typedef struct {
    bit          rd;
    logic [31:0] rp;
    bit          ir;
    bit          rv;
    logic [31:0] addr;
    bit          iv;
    logic [31:0] ipc;
  } vec_t;

  mreq_t       mem_q[$];
  inst_t       rdy_q[$];
  logic [31:0] m_pc;
  int          epoch;
  int          cyc;
  int          last_due;
  int          lat_min = 1;
  int          lat_max = 1;
  int          n_chk = 0;
  int          n_fail = 0;

  logic        o_rv;
  logic        o_iv;
  logic [31:0] o_addr;
  logic [31:0] o_ipc;
  logic [31:0] o_ipc4;

  always @(negedge clk) begin
    if (rst_n) assert (!(f.imem_rsp_valid && mem_q.size() == 0))
      else $error("FAIL protocol: response with nothing outstanding");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic idle_inputs();
    f.imem_req_ready = 1'b0;
    f.imem_rsp_valid = 1'b0;
    f.imem_rsp_data  = '0;
    f.redirect_valid = 1'b0;
    f.redirect_pc    = '0;
    f.inst_ready     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    mem_q.delete();
    rdy_q.delete();
    m_pc  = RESET_PC;
    epoch = epoch + 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc      = 0;
    last_due = -1;
  endtask

  // One clock: drive at posedge+1, compare at negedge, advance the model at the next posedge
  task automatic cycle(input bit rr, input bit ir, input bit rd, input logic [31:0] rp);
    bit    rsp;
    bit    fire;
    bit    deq;
    bit    exp_rv;
    bit    exp_iv;
    int    due;
    mreq_t e;
    f.imem_req_ready = rr;
    f.inst_ready     = ir;
    f.redirect_valid = rd;
    f.redirect_pc    = rp;
    rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    f.imem_rsp_valid = rsp;
    f.imem_rsp_data  = rsp ? mem_q[0].data : $urandom;
    @(negedge clk);
    exp_rv = ((mem_q.size() + rdy_q.size()) < DEPTH) && !rd;
    exp_iv = (rdy_q.size() > 0);
    o_rv   = f.imem_req_valid;
    o_iv   = f.inst_valid;
    o_addr = f.imem_req_addr;
    o_ipc  = f.inst_pc;
    o_ipc4 = f.inst_pc_plus4;
    check("req_valid", 32'(o_rv), 32'(exp_rv));
    check("req_addr", o_addr, m_pc);
    check("inst_valid", 32'(o_iv), 32'(exp_iv));
    if (exp_iv) begin
      check("inst_pc", o_ipc, rdy_q[0].pc);
      check("inst_data", f.inst_data, rdy_q[0].data);
      check("inst_pc_plus4", o_ipc4, rdy_q[0].pc + 32'd4);
    end
    fire = f.imem_req_valid && rr;
    deq  = exp_iv && ir;
    @(posedge clk);
    if (rsp) begin
      e = mem_q.pop_front();
      if (e.epoch == epoch && !rd) rdy_q.push_back('{e.addr, e.data});
    end
    if (fire) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      mem_q.push_back('{m_pc, $urandom, (rd ? -1 : epoch), due});
      last_due = due;
    end
    if (rd) begin
      rdy_q.delete();
      epoch = epoch + 1;
      m_pc  = {rp[31:2], 2'b00};
    end else begin
      if (deq)  void'(rdy_q.pop_front());
      if (fire) m_pc = m_pc + 32'd4;
    end
    cyc++;
    #1;
  endtask

  initial begin : main
    vec_t tbl [14];
    bit   seen;

    tbl[0]  = '{1, 32'h0000_0002, 0, 0, 32'h0000_0100, 0, 32'h0};
    tbl[1]  = '{0, 32'h0,         0, 1, 32'h0000_0000, 0, 32'h0};
    tbl[2]  = '{0, 32'h0,         0, 1, 32'h0000_0004, 0, 32'h0};
    tbl[3]  = '{0, 32'h0,         0, 1, 32'h0000_0008, 1, 32'h0000_0000};
    tbl[4]  = '{0, 32'h0,         0, 1, 32'h0000_000C, 1, 32'h0000_0000};
    tbl[5]  = '{0, 32'h0,         0, 0, 32'h0000_0010, 1, 32'h0000_0000};
    tbl[6]  = '{0, 32'h0,         1, 0, 32'h0000_0010, 1, 32'h0000_0000};
    tbl[7]  = '{0, 32'h0,         1, 1, 32'h0000_0010, 1, 32'h0000_0004};
    tbl[8]  = '{0, 32'h0,         1, 1, 32'h0000_0014, 1, 32'h0000_0008};
    tbl[9]  = '{0, 32'h0,         1, 1, 32'h0000_0018, 1, 32'h0000_000C};
    tbl[10] = '{1, 32'h0000_2002, 1, 0, 32'h0000_001C, 1, 32'h0000_0010};
    tbl[11] = '{0, 32'h0,         1, 1, 32'h0000_2000, 0, 32'h0};
    tbl[12] = '{0, 32'h0,         1, 1, 32'h0000_2004, 0, 32'h0};
    tbl[13] = '{0, 32'h0,         1, 1, 32'h0000_2008, 1, 32'h0000_2000};

    epoch = 0;

    // Reset state and sustained one-per-cycle delivery from RESET_PC
    do_reset();
    #1;
    check("rst_inst_valid", 32'(f.inst_valid), 32'd0);
    check("rst_req_addr", f.imem_req_addr, RESET_PC);
    lat_min = 1; lat_max = 1;
    for (int c = 0; c < 12; c++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      if (c == 0) check("first_req_valid", 32'(o_rv), 32'd1);
      if (c >= 2) begin
        check("stream_valid", 32'(o_iv), 32'd1);
        check("stream_pc", o_ipc, RESET_PC + 32'(4 * (c - 2)));
      end else begin
        check("stream_early_valid", 32'(o_iv), 32'd0);
      end
    end

    // Table: fill with no consumer, release, then redirect colliding with response and dequeue
    do_reset();
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, tbl[i].ir, tbl[i].rd, tbl[i].rp);
      check($sformatf("tbl%0d_req_valid", i), 32'(o_rv), 32'(tbl[i].rv));
      check($sformatf("tbl%0d_req_addr", i), o_addr, tbl[i].addr);
      check($sformatf("tbl%0d_inst_valid", i), 32'(o_iv), 32'(tbl[i].iv));
      if (tbl[i].iv) check($sformatf("tbl%0d_inst_pc", i), o_ipc, tbl[i].ipc);
    end

    // Redirect with three requests in flight on a 3-cycle memory
    do_reset();
    lat_min = 3; lat_max = 3;
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_2002);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_req_valid", 32'(o_rv), 32'd1);
    check("redir_req_addr", o_addr, 32'h0000_2000);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      if (o_iv) begin
        seen = 1'b1;
        check("redir_first_pc", o_ipc, 32'h0000_2000);
      end
    end
    if (!seen) check("redir_timeout", 32'd0, 32'd1);

    // PC wrap at the top of the address space
    do_reset();
    lat_min = 1; lat_max = 1;
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_addr0", o_addr, 32'hFFFF_FFF8);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_addr1", o_addr, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_addr2", o_addr, 32'h0000_0000);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_pc", o_ipc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", o_ipc4, 32'h0000_0000);

    // Asynchronous reset while full with responses outstanding
    do_reset();
    lat_min = 2; lat_max = 2;
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("full_req_valid", 32'(f.imem_req_valid), 32'd0);
    check("full_inst_valid", 32'(o_iv), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_inst_valid", 32'(f.inst_valid), 32'd0);
    check("async_rst_req_addr", f.imem_req_addr, RESET_PC);
    do_reset();
    lat_min = 1; lat_max = 1;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("restart_req_valid", 32'(o_rv), 32'd1);
    check("restart_req_addr", o_addr, RESET_PC);
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("restart_pc", o_ipc, RESET_PC + 32'd8);

    // Randomised traffic against the reference model
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      bit          rr;
      bit          ir;
      bit          rd;
      logic [31:0] rp;
      rr = ($urandom_range(0, 3) != 0);
      ir = ((i % 200) < 40) ? 1'b0 : ($urandom_range(0, 9) < 7);
      rd = ($urandom_range(0, 39) == 0);
      rp = $urandom;
      cycle(rr, ir, rd, rp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
